// File: rtl/riscv_pkg.sv
// Shared RV32I load/store encodings, LSU state type and access-legality helper.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP,
        ST_DONE
    } lsu_state_t;

    // True when the access must be refused: bad alignment, or a funct3 with no
    // meaning for this direction (unsigned variants exist only for loads).
    function automatic logic access_bad(input logic we, input logic [2:0] f3,
                                        input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b1;
        case (f3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = addr_lo[0];
            F3_W:    bad = (addr_lo != 2'b00);
            F3_BU:   bad = we;
            F3_HU:   bad = we | addr_lo[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store byte enables / replicated data, load extract and extend.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_word,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    output logic [31:0] ld_data
);

    logic [31:0] ld_shift;

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = st_data;
        case (funct3[1:0])
            2'd0: begin
                st_be    = 4'b0001 << addr_lo;
                st_wdata = {4{st_data[7:0]}};
            end
            2'd1: begin
                st_be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{st_data[15:0]}};
            end
            default: ;
        endcase
    end

    assign ld_shift = ld_word >> {addr_lo, 3'b000};

    always_comb begin
        ld_data = ld_shift;
        case (funct3)
            F3_B:    ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
            F3_H:    ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
            F3_BU:   ld_data = {24'd0, ld_shift[7:0]};
            F3_HU:   ld_data = {16'd0, ld_shift[15:0]};
            default: ld_data = ld_shift;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle data-memory stage: one outstanding req/gnt/rvalid access, stalls the
// core until completion and hands load results to the register file.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        stall,
    output logic        done,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wb_we,
    output logic [4:0]  wb_wa,
    output logic [31:0] wb_wd,
    output logic        err_misaligned,
    output logic        err_timeout
);

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    lsu_state_t  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        err_mis_q, err_mis_d;
    logic        err_to_q, err_to_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] data_q, data_d;

    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;
    logic        in_idle, in_req, in_resp, in_done;

    lsu_align u_align (
        .funct3   (funct3_q),
        .addr_lo  (addr_q[1:0]),
        .st_data  (wdata_q),
        .ld_word  (mem_rdata),
        .st_be    (st_be),
        .st_wdata (st_wdata),
        .ld_data  (ld_data)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_mis_d = err_mis_q;
        err_to_d  = err_to_q;
        we_d      = we_q;
        funct3_d  = funct3_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_d      = rd_q;
        data_d    = data_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d      = req_we;
                    funct3_d  = req_funct3;
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    rd_d      = req_rd;
                    err_to_d  = 1'b0;
                    err_mis_d = access_bad(req_we, req_funct3, req_addr[1:0]);
                    state_d   = err_mis_d ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_gnt) begin
                    cnt_d   = 16'd0;
                    state_d = we_q ? ST_DONE : ST_RESP;
                end
            end
            ST_RESP: begin
                // A response on the final permitted cycle still counts as success.
                if (mem_rvalid) begin
                    data_d  = ld_data;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_to_d = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 16'd0;
            err_mis_q <= 1'b0;
            err_to_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_mis_q <= err_mis_d;
            err_to_q  <= err_to_d;
        end
    end

    always_ff @(posedge clk) begin
        we_q     <= we_d;
        funct3_q <= funct3_d;
        addr_q   <= addr_d;
        wdata_q  <= wdata_d;
        rd_q     <= rd_d;
        data_q   <= data_d;
    end

    assign in_idle = (state_q == ST_IDLE);
    assign in_req  = (state_q == ST_REQ);
    assign in_resp = (state_q == ST_RESP);
    assign in_done = (state_q == ST_DONE);

    assign req_ready      = in_idle;
    assign stall          = (req_valid & in_idle) | in_req | in_resp;
    assign done           = in_done;
    assign mem_req        = in_req;
    assign mem_we         = in_req & we_q;
    assign mem_addr       = in_req ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem_be         = in_req ? st_be : 4'd0;
    assign mem_wdata      = in_req ? st_wdata : 32'd0;
    assign err_misaligned = in_done & err_mis_q;
    assign err_timeout    = in_done & err_to_q;
    assign wb_we          = in_done & ~we_q & ~err_mis_q & ~err_to_q & (rd_q != 5'd0);
    assign wb_wa          = wb_we ? rd_q : 5'd0;
    assign wb_wd          = wb_we ? data_q : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized and directed bench for load_store_unit against a transaction-level model.
module tb_load_store_unit;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [4:0]  req_rd = 5'd0;
    logic        stall, done, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        wb_we, err_misaligned, err_timeout;
    logic [4:0]  wb_wa;
    logic [31:0] wb_wd;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd), .stall(stall), .done(done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
        .err_misaligned(err_misaligned), .err_timeout(err_timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // One access: gd = cycles mem_gnt is held low in REQ, rdel = cycles before
    // mem_rvalid in RESP (rdel >= T means the response never comes).
    task automatic do_access(input string tag, input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [4:0] rd, input int gd, input int rdel,
                             input logic [31:0] word);
        int size, lo, d_exp, t_done, badc;
        logic illegal, mis, timeout, exp_wb;
        logic [31:0] exp_be, exp_wdata, v;

        size    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        lo      = int'(addr[1:0]);
        illegal = we ? (f3 >= 3'd3) : (f3 == 3'd3 || f3 >= 3'd6);
        mis     = illegal || (lo % size != 0);
        timeout = !mis && !we && (rdel >= T);
        exp_be  = ((32'd1 << size) - 32'd1) << lo;
        exp_wdata = (size == 1) ? (wdata & 32'hFF) * 32'h0101_0101 :
                    (size == 2) ? (wdata & 32'hFFFF) * 32'h0001_0001 : wdata;
        v = word >> (8 * lo);
        if (size == 1) begin
            v = v & 32'hFF;
            if (f3 == 3'd0 && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else if (size == 2) begin
            v = v & 32'hFFFF;
            if (f3 == 3'd1 && v >= 32'd32768) v = v + 32'hFFFF_0000;
        end
        exp_wb = !we && !mis && !timeout && (rd != 5'd0);
        if (mis)          d_exp = 1;
        else if (we)      d_exp = 2 + gd;
        else if (timeout) d_exp = 2 + gd + T;
        else              d_exp = 3 + gd + rdel;

        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3;
        req_addr = addr; req_wdata = wdata; req_rd = rd;
        #1;
        check({tag, "_ready_stall"}, {req_ready, stall}, 2'b11);

        t_done = 0;
        badc   = 0;
        for (int t = 1; t <= d_exp + 20 && t_done == 0; t++) begin
            @(negedge clk);
            if (t <= d_exp) begin
                logic exp_req;
                exp_req = !mis && (t <= 1 + gd);
                if (mem_req !== exp_req) badc++;
                if (exp_req && (mem_addr !== {addr[31:2], 2'b00} || mem_we !== we)) badc++;
                if (exp_req && we && ({28'd0, mem_be} !== exp_be || mem_wdata !== exp_wdata)) badc++;
                if (stall !== (t < d_exp)) badc++;
                if (req_ready !== 1'b0) badc++;
            end
            if (done === 1'b1) begin
                t_done = t;
                check({tag, "_err"}, {err_misaligned, err_timeout}, {mis, timeout});
                check({tag, "_wb_we"}, wb_we, exp_wb);
                if (exp_wb) begin
                    check({tag, "_wb_wa"}, wb_wa, rd);
                    check({tag, "_wb_wd"}, wb_wd, v);
                end
            end
            mem_gnt    = !mis && (t == 1 + gd);
            mem_rvalid = !mis && !we && (rdel < T) && (t == 2 + gd + rdel);
            mem_rdata  = mem_rvalid ? word : $urandom;
            if (t_done != 0) req_valid = 1'b0;
        end
        req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        check({tag, "_done_cycle"}, t_done, d_exp);
        check({tag, "_timeline"}, badc, 0);
        @(negedge clk);
        check({tag, "_back_idle"}, {req_ready, done, mem_req}, 3'b100);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_ctrl", {req_ready, stall, done, mem_req, mem_we, err_misaligned,
                             err_timeout, wb_we}, 8'b1000_0000);
        check("reset_data", mem_addr | mem_wdata | wb_wd, 32'd0);
        check("reset_be_wa", {mem_be, wb_wa}, 9'd0);
        rst = 1'b0;

        do_access("sw",      1'b1, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 5'd5, 0, 0, 32'd0);
        do_access("lb",      1'b0, 3'd0, 32'h0000_0103, 32'd0, 5'd3, 0, 0, 32'h80FF_FF01);
        do_access("lbu",     1'b0, 3'd4, 32'h0000_0103, 32'd0, 5'd3, 0, 0, 32'h80FF_FF01);
        do_access("sh",      1'b1, 3'd1, 32'h0000_0102, 32'h1234_ABCD, 5'd0, 1, 0, 32'd0);
        do_access("lw_mis",  1'b0, 3'd2, 32'h0000_0102, 32'd0, 5'd4, 0, 0, 32'd0);
        do_access("sb_ill",  1'b1, 3'd4, 32'h0000_0100, 32'd7, 5'd4, 0, 0, 32'd0);
        do_access("lw_gnt5", 1'b0, 3'd2, 32'h0000_2000, 32'd0, 5'd9, 5, 1, 32'hCAFE_F00D);
        do_access("lw_last", 1'b0, 3'd2, 32'h0000_2004, 32'd0, 5'd9, 0, T - 1, 32'h1357_9BDF);
        do_access("lw_tmo",  1'b0, 3'd2, 32'h0000_2008, 32'd0, 5'd9, 0, T + 6, 32'h0);
        do_access("lh_neg",  1'b0, 3'd1, 32'h0000_0042, 32'd0, 5'd1, 0, 2, 32'h8001_7FFF);

        // Reset in RESP, then a stray response that must be ignored.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2;
        req_addr = 32'h40; req_rd = 5'd7;
        @(negedge clk);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
        #1;
        check("rst_resp_ctrl", {req_ready, stall, done, mem_req, err_misaligned,
                                err_timeout, wb_we}, 7'b1000000);
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("rst_stray_rvalid", {req_ready, done, mem_req, wb_we}, 4'b1000);
        check("rst_stray_data", wb_wd | mem_addr, 32'd0);

        do_access("lw_x0", 1'b0, 3'd2, 32'h0000_0010, 32'd0, 5'd0, 0, 0, 32'hFFFF_FFFF);

        for (int i = 0; i < 40; i++) begin
            logic        we;
            logic [2:0]  f3;
            logic [31:0] a;
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom & 32'h0000_FFFF;
            do_access($sformatf("rnd%0d", i), we, f3, a, $urandom,
                      5'($urandom_range(0, 31)), $urandom_range(0, 3),
                      $urandom_range(0, T + 1), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
